// File: rtl/tc_seg_display_if.sv
// Value-in / display-out bundle between the counter value register and the 7-segment pins.
interface tc_seg_display_if #(
  parameter int unsigned BIT_WIDTH = 16,
  parameter int unsigned DIGITS    = 5
);
  logic [BIT_WIDTH-1:0] value;
  logic [6:0]           seg;
  logic [DIGITS-1:0]    an;
  logic                 busy;

  modport master (output value, input seg, input an, input busy);
  modport slave  (input value, output seg, output an, output busy);
endinterface

// File: rtl/tc_seg_display.sv
// Binary-to-BCD (sequential double-dabble) converter feeding a time-multiplexed
// 7-segment scanner with leading-zero blanking.
module tc_seg_display #(
  parameter int unsigned BIT_WIDTH  = 16,
  parameter int unsigned DIGITS     = 5,
  parameter int unsigned SCAN_DIV   = 1000,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  tc_seg_display_if.slave bus
);
  localparam int unsigned BCD_W  = 4 * DIGITS;
  localparam int unsigned CNT_W  = $clog2(BIT_WIDTH + 1);
  localparam int unsigned TICK_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [6:0]        SEG_OFF = {7{ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] AN_OFF  = {DIGITS{ACTIVE_LOW}};

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_e;

  state_e               state_q, state_d;
  logic [BIT_WIDTH-1:0] last_q, last_d;
  logic [BIT_WIDTH-1:0] shreg_q, shreg_d;
  logic [BCD_W-1:0]     bcd_q, bcd_d, bcd_adj;
  logic [BCD_W-1:0]     disp_q, disp_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [TICK_W-1:0]    tick_q, tick_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [6:0]           seg_q, seg_d, seg_raw;
  logic [DIGITS-1:0]    an_q, an_d, an_raw;
  logic                 busy_q, busy_d;
  logic [3:0]           nib;
  logic                 lit;

  // Active-high segment code {g,f,e,d,c,b,a}; non-decimal nibbles are blank.
  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  // Converter: restart whenever the observed value differs from the last one converted.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    shreg_d = shreg_q;
    bcd_d   = bcd_q;
    disp_d  = disp_q;
    cnt_d   = cnt_q;
    bcd_adj = bcd_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    case (state_q)
      IDLE: begin
        if (bus.value != last_q) begin
          shreg_d = bus.value;
          last_d  = bus.value;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {bcd_d, shreg_d} = {bcd_adj, shreg_q} << 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BIT_WIDTH - 1)) state_d = COMMIT;
      end
      COMMIT: begin
        disp_d  = bcd_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Scanner and output register; digit i>0 blanks when it and every higher nibble are zero.
  always_comb begin
    tick_d = tick_q + TICK_W'(1);
    idx_d  = idx_q;
    if (tick_q == TICK_W'(SCAN_DIV - 1)) begin
      tick_d = '0;
      idx_d  = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
    nib    = '0;
    lit    = 1'b0;
    an_raw = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (IDX_W'(i) == idx_q) begin
        nib       = disp_q[4*i +: 4];
        an_raw[i] = 1'b1;
      end
      if ((IDX_W'(i) >= idx_q) && (disp_q[4*i +: 4] != 4'd0)) lit = 1'b1;
    end
    if (idx_q == '0) lit = 1'b1;
    seg_raw = lit ? seg_decode(nib) : 7'h00;
    seg_d   = seg_raw ^ SEG_OFF;
    an_d    = an_raw ^ AN_OFF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= '0;
      shreg_q <= '0;
      bcd_q   <= '0;
      disp_q  <= '0;
      cnt_q   <= '0;
      tick_q  <= '0;
      idx_q   <= '0;
      seg_q   <= SEG_OFF;
      an_q    <= AN_OFF;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      shreg_q <= shreg_d;
      bcd_q   <= bcd_d;
      disp_q  <= disp_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.seg  = seg_q;
  assign bus.an   = an_q;
  assign bus.busy = busy_q;
endmodule
